// File: rtl/mips_multicycle.sv
// Multicycle MIPS-subset core: shared ALU, one unified memory port with a ready handshake, sticky illegal trap.
// Optional bne support is compiled in when MIPS_BNE_EN is defined.
module mips_multicycle #(
  parameter logic [31:0] RESET_PC = 32'h0000_0000
) (
  input  logic        clk,
  input  logic        reset,
  output logic [31:0] memaddr,
  output logic [31:0] memwdata,
  output logic        memread,
  output logic        memwrite,
  input  logic [31:0] memrdata,
  input  logic        memready,
  output logic        illegal,
  output logic [3:0]  dbg_state_o
);

  // Memory handshake: a request (memread in FETCH/MEMRD, memwrite in MEMWR) completes on
  // the rising edge where memready=1; until then address, data and strobes stay stable.
  typedef enum logic [3:0] {
    S_FETCH, S_DECODE, S_MEMADR, S_MEMRD, S_MEMWB, S_MEMWR, S_EXEC,
    S_ALUWB, S_ADDIEX, S_ADDIWB, S_BRANCH, S_JUMP, S_TRAP
  } state_t;

  localparam logic [5:0] OP_RTYPE = 6'b000000;
  localparam logic [5:0] OP_J     = 6'b000010;
  localparam logic [5:0] OP_BEQ   = 6'b000100;
  localparam logic [5:0] OP_BNE   = 6'b000101;
  localparam logic [5:0] OP_ADDI  = 6'b001000;
  localparam logic [5:0] OP_LW    = 6'b100011;
  localparam logic [5:0] OP_SW    = 6'b101011;

  localparam logic [5:0] FN_ADD = 6'b100000;
  localparam logic [5:0] FN_SUB = 6'b100010;
  localparam logic [5:0] FN_AND = 6'b100100;
  localparam logic [5:0] FN_OR  = 6'b100101;
  localparam logic [5:0] FN_SLT = 6'b101010;

  state_t      state_q, state_d;
  logic [31:0] pc_q, pc_d, ir_q, ir_d, mdr_q, mdr_d;
  logic [31:0] a_q, a_d, b_q, b_d, aluout_q, aluout_d;
  logic [31:0] memaddr_q, memaddr_d, memwdata_q, memwdata_d;
  logic        memread_q, memread_d, memwrite_q, memwrite_d, illegal_q, illegal_d;

  logic [31:0] rf_q [32];
  logic        rf_we;
  logic [4:0]  rf_waddr;
  logic [31:0] rf_wdata;

  logic [5:0]  op, funct;
  logic [4:0]  rs, rt, rd;
  logic [31:0] imm_sext, rs_val, rt_val, sub_res, alu_res;
  logic        funct_ok, br_taken;

  assign op       = ir_q[31:26];
  assign rs       = ir_q[25:21];
  assign rt       = ir_q[20:16];
  assign rd       = ir_q[15:11];
  assign funct    = ir_q[5:0];
  assign imm_sext = {{16{ir_q[15]}}, ir_q[15:0]};
  assign rs_val   = (rs == 5'd0) ? 32'h0 : rf_q[rs];
  assign rt_val   = (rt == 5'd0) ? 32'h0 : rf_q[rt];
  assign sub_res  = a_q - b_q;

  // slt takes the sign of the raw difference, with no overflow correction.
  always_comb begin
    alu_res  = 32'h0;
    funct_ok = 1'b1;
    case (funct)
      FN_ADD:  alu_res = a_q + b_q;
      FN_SUB:  alu_res = sub_res;
      FN_AND:  alu_res = a_q & b_q;
      FN_OR:   alu_res = a_q | b_q;
      FN_SLT:  alu_res = {31'h0, sub_res[31]};
      default: funct_ok = 1'b0;
    endcase
  end

`ifdef MIPS_BNE_EN
  assign br_taken = (op == OP_BNE) ? (a_q != b_q) : (a_q == b_q);
`else
  assign br_taken = (a_q == b_q);
`endif

  always_comb begin
    state_d  = state_q;
    pc_d     = pc_q;
    ir_d     = ir_q;
    mdr_d    = mdr_q;
    a_d      = a_q;
    b_d      = b_q;
    aluout_d = aluout_q;
    rf_we    = 1'b0;
    rf_waddr = rt;
    rf_wdata = aluout_q;
    case (state_q)
      S_FETCH: if (memready) begin
        ir_d    = memrdata;
        pc_d    = pc_q + 32'd4;
        state_d = S_DECODE;
      end
      S_DECODE: begin
        a_d      = rs_val;
        b_d      = rt_val;
        aluout_d = pc_q + (imm_sext << 2);
        case (op)
          OP_LW, OP_SW: state_d = S_MEMADR;
          OP_RTYPE:     state_d = funct_ok ? S_EXEC : S_TRAP;
          OP_BEQ:       state_d = S_BRANCH;
`ifdef MIPS_BNE_EN
          OP_BNE:       state_d = S_BRANCH;
`endif
          OP_ADDI:      state_d = S_ADDIEX;
          OP_J:         state_d = S_JUMP;
          default:      state_d = S_TRAP;
        endcase
      end
      S_MEMADR: begin
        aluout_d = a_q + imm_sext;
        state_d  = (op == OP_LW) ? S_MEMRD : S_MEMWR;
      end
      S_MEMRD: if (memready) begin
        mdr_d   = memrdata;
        state_d = S_MEMWB;
      end
      S_MEMWB: begin
        rf_we    = 1'b1;
        rf_wdata = mdr_q;
        state_d  = S_FETCH;
      end
      S_MEMWR:  if (memready) state_d = S_FETCH;
      S_EXEC: begin
        aluout_d = alu_res;
        state_d  = S_ALUWB;
      end
      S_ALUWB: begin
        rf_we    = 1'b1;
        rf_waddr = rd;
        state_d  = S_FETCH;
      end
      S_ADDIEX: begin
        aluout_d = a_q + imm_sext;
        state_d  = S_ADDIWB;
      end
      S_ADDIWB: begin
        rf_we   = 1'b1;
        state_d = S_FETCH;
      end
      S_BRANCH: begin
        if (br_taken) pc_d = aluout_q;
        state_d = S_FETCH;
      end
      S_JUMP: begin
        pc_d    = {pc_q[31:28], ir_q[25:0], 2'b00};
        state_d = S_FETCH;
      end
      default: state_d = S_TRAP;
    endcase
  end

  // Port outputs are registered from the next state so they line up with the state they describe.
  always_comb begin
    memread_d  = (state_d == S_FETCH) || (state_d == S_MEMRD);
    memwrite_d = (state_d == S_MEMWR);
    illegal_d  = (state_d == S_TRAP);
    memwdata_d = (state_d == S_MEMWR) ? b_d : 32'h0;
    memaddr_d  = 32'h0;
    if (state_d == S_FETCH) memaddr_d = pc_d;
    else if ((state_d == S_MEMRD) || (state_d == S_MEMWR)) memaddr_d = aluout_d;
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q    <= S_FETCH;
      pc_q       <= RESET_PC;
      ir_q       <= 32'h0;
      mdr_q      <= 32'h0;
      a_q        <= 32'h0;
      b_q        <= 32'h0;
      aluout_q   <= 32'h0;
      memaddr_q  <= RESET_PC;
      memwdata_q <= 32'h0;
      memread_q  <= 1'b1;
      memwrite_q <= 1'b0;
      illegal_q  <= 1'b0;
    end else begin
      state_q    <= state_d;
      pc_q       <= pc_d;
      ir_q       <= ir_d;
      mdr_q      <= mdr_d;
      a_q        <= a_d;
      b_q        <= b_d;
      aluout_q   <= aluout_d;
      memaddr_q  <= memaddr_d;
      memwdata_q <= memwdata_d;
      memread_q  <= memread_d;
      memwrite_q <= memwrite_d;
      illegal_q  <= illegal_d;
    end
  end

  // Register file has no reset; r0 writes are dropped and reset suppresses writeback.
  always_ff @(posedge clk) begin
    if (rf_we && !reset && (rf_waddr != 5'd0)) rf_q[rf_waddr] <= rf_wdata;
  end

  assign memaddr     = memaddr_q;
  assign memwdata    = memwdata_q;
  assign memread     = memread_q;
  assign memwrite    = memwrite_q;
  assign illegal     = illegal_q;
  assign dbg_state_o = state_q;

endmodule

// File: doc/mips_multicycle.md
# mips_multicycle

Multicycle MIPS-subset core that runs one instruction over 3–5 clock cycles through a shared ALU and a single unified instruction/data memory port. It is the next-generation replacement for the single-cycle `mips` core. It adds a parametrised reset vector, a memory-ready handshake for wait-stated memory, an illegal-opcode trap, and an optional `bne`. It sits under a `top` beside one unified memory model.

## Interface
- `RESET_PC`, default 32'h0000_0000: PC value loaded on reset.
- `clk` in 1: the only clock; all state changes on the rising edge.
- `reset` in 1: synchronous, active-high.
- `memaddr` out 32: memory word address (byte address, word aligned).
- `memwdata` out 32: store data.
- `memread` out 1: read request; valid in FETCH and MEMRD.
- `memwrite` out 1: write strobe; valid in MEMWR.
- `memrdata` in 32: read data; sampled on the edge where `memready`=1.
- `memready` in 1: access completes on any edge where this is 1 during a request.
- `illegal` out 1: sticky trap flag.

## Operation
- Registers:
  - PC, IR, MDR, A, B, ALUOut: 32 bits each.
  - Register file: 32x32; r0 reads 0 and writes to it are dropped; written on posedge. The register file is not reset.
- Supported instructions: `lw`, `sw`, `add`, `sub`, `and`, `or`, `slt`, `beq`, `addi`, `j`.
- ALU:
  - The ALU is identical in function to the existing ALU.
  - `slt` is signed (sign of a−b without overflow correction).
  - Arithmetic wraps modulo 2^32; no overflow traps.
- FSM states and transitions:
  - FETCH:
    - memaddr=PC, memread=1.
    - On memready: IR←memrdata, PC←PC+4, go to DECODE.
    - Otherwise hold (PC and IR unchanged).
  - DECODE:
    - A←rf[rs], B←rf[rt], ALUOut←PC+(signext(imm)<<2).
    - Dispatch on op: lw/sw→MEMADR, R-type→EXEC, beq→BRANCH, addi→ADDIEX, j→JUMP, anything else→TRAP.
    - An unknown R-type funct also goes to TRAP.
  - MEMADR: ALUOut←A+signext(imm); lw→MEMRD, sw→MEMWR.
  - MEMRD: memaddr=ALUOut, memread=1; on memready, MDR←memrdata, go to MEMWB; otherwise hold.
  - MEMWB: rf[rt]←MDR; go to FETCH.
  - MEMWR: memaddr=ALUOut, memwdata=B, memwrite=1; on memready go to FETCH; otherwise hold with outputs stable.
  - EXEC: ALUOut←A op B; go to ALUWB.
  - ALUWB: rf[rd]←ALUOut; go to FETCH.
  - ADDIEX: ALUOut←A+signext(imm); go to ADDIWB.
  - ADDIWB: rf[rt]←ALUOut; go to FETCH.
  - BRANCH: if A==B, PC←ALUOut; go to FETCH.
  - JUMP: PC←{PC[31:28], IR[25:0], 2'b00}; go to FETCH.
  - TRAP: illegal=1; stay here until reset. No memory requests and no register writes.
- memread and memwrite are never both 1. Both are 0 outside the states listed above.
- memaddr and memwdata are don't-care when no request is active. They are driven to 0 in idle states for determinism.

## Timing
- Reset:
  - Sampled on the rising edge. On that edge: state←FETCH, PC←RESET_PC, IR/MDR/A/B/ALUOut←0, illegal←0.
  - Reset wins over every other event, including a reset asserted mid-instruction or mid-wait.
  - A pending store issued in MEMWR is abandoned if reset coincides; memwrite is 0 in the following cycle.
- Cycles per instruction with memready tied to 1: beq 3, j 3, R-type 4, addi 4, sw 4, lw 5.
- Each cycle memready is held low in FETCH/MEMRD/MEMWR adds one cycle. memready is ignored in all other states.
- First fetch: in the cycle after reset deasserts, memread=1 and memaddr=RESET_PC.
- Register file write in a writeback state is visible to the DECODE of the next instruction.
- Branch target is PC+4+(imm<<2), computed in DECODE from the already incremented PC. Wrap-around past 32'hFFFF_FFFC is modulo 2^32.

## Configuration
- `MIPS_BNE_EN`:
  - Defined: opcode 6'b000101 (`bne`) dispatches to BRANCH with an inverted condition (taken when A!=B). It takes 3 cycles.
  - Undefined: opcode 6'b000101 goes to TRAP.

## Test plan
- Reset and first fetch: with RESET_PC=32'h40, hold reset 2 cycles then release → first cycle shows memread=1, memaddr=32'h40; after a handshake the next fetch address is 32'h44.
- ALU and store: `addi $2,$0,5`; `addi $3,$0,2`; `add $7,$2,$3`; `sw $7,84($0)` with memready=1 → memwrite=1, memaddr=84, memwdata=7 on cycle 16 after reset release.
- Load wait states: `lw $4,84($0)` with memready low for 3 cycles in MEMRD → instruction takes 8 cycles; $4=7 is observed by a following `sw $4,88($0)`.
- Branch: `beq $0,$0,+2` → next fetch address is PC+12. `beq` with unequal registers → next fetch address is PC+4. Each takes 3 cycles.
- Illegal opcode: fetch 32'hFC00_0000 → illegal=1 from the cycle after DECODE; no memread or memwrite for 20 cycles. Reset clears illegal and restarts at RESET_PC.
- `bne`: `bne $2,$3,-1` with $2≠$3 → next fetch is the same PC when `MIPS_BNE_EN` is defined; illegal=1 when it is not.
